// File: rtl/sar_search_4_if.sv
// Handshake and comparator bus for the successive-approximation search engine.
// master = requester/comparator side, slave = search engine.
interface sar_search_4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             gt;
    logic             lt;
    logic             eq;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (output start, gt, lt, eq, input guess, busy, done, result, err);
    modport slave  (input start, gt, lt, eq, output guess, busy, done, result, err);
endinterface

// File: rtl/sar_search_4.sv
// SAR search: drives guess into an external comparator, resolves MSB->LSB, exits early on eq.
// Optional SAR_ONEHOT_CHECK_EN aborts with err when the {gt,lt,eq} flags are not one-hot.
module sar_search_4 #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sar_search_4_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] guess, guess_n, result, result_n, g;
    logic [IW-1:0]    idx, idx_n, idx_m1;
    logic             busy, busy_n, done, done_n;
`ifdef SAR_ONEHOT_CHECK_EN
    logic             err, err_n;
`endif

    assign idx_m1 = idx - 1'b1;

    always_comb begin
        state_n  = state;
        guess_n  = guess;
        idx_n    = idx;
        busy_n   = busy;
        done_n   = 1'b0;
        result_n = result;
`ifdef SAR_ONEHOT_CHECK_EN
        err_n    = err;
`endif
        g        = guess;
        case (state)
            IDLE: if (bus.start) begin
                guess_n = {1'b1, {(WIDTH-1){1'b0}}};
                idx_n   = IW'(WIDTH - 1);
                state_n = RUN;
                busy_n  = 1'b1;
`ifdef SAR_ONEHOT_CHECK_EN
                err_n   = 1'b0;
`endif
            end
            RUN: begin
                // lt clears the bit under test; gt (or no flag) keeps it
                if (bus.lt && !bus.eq) g[idx] = 1'b0;
`ifdef SAR_ONEHOT_CHECK_EN
                if (!$onehot({bus.gt, bus.lt, bus.eq})) begin
                    err_n    = 1'b1;
                    result_n = guess;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end else
`endif
                if (bus.eq) begin
                    result_n = guess;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end else if (idx == '0) begin
                    result_n = g;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end else begin
                    guess_n         = g;
                    guess_n[idx_m1] = 1'b1;
                    idx_n           = idx_m1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            guess  <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
`ifdef SAR_ONEHOT_CHECK_EN
            err    <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            guess  <= guess_n;
            idx    <= idx_n;
            busy   <= busy_n;
            done   <= done_n;
            result <= result_n;
`ifdef SAR_ONEHOT_CHECK_EN
            err    <= err_n;
`endif
        end
    end

    assign bus.guess  = guess;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
`ifdef SAR_ONEHOT_CHECK_EN
    assign bus.err    = err;
`else
    assign bus.err    = 1'b0;
`endif
endmodule

// File: tb/tb_sar_search_4.sv
// Directed bench for sar_search_4: behavioural comparator on a hidden value, optional flag fault injection.
module tb_sar_search_4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = 4'd0;
    logic       fz = 1'b0;
    logic       fgt = 1'b0, flt = 1'b0, feq = 1'b0;
    int         nchk = 0;
    int         nerr = 0;

    sar_search_4_if #(.WIDTH(4)) bus ();

    sar_search_4 #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign bus.gt = fz ? fgt : (a > bus.guess);
    assign bus.lt = fz ? flt : (a < bus.guess);
    assign bus.eq = fz ? feq : (a == bus.guess);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start pulse, then wait (bounded) for done; returns clocks from start edge to done
    task automatic run(input logic [3:0] av, output int n);
        a = av;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int dones;
        bus.start = 1'b0;
        repeat (2) tick();
        chk("rst_guess", 32'(bus.guess), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_err", 32'(bus.err), 0);
        rst_n = 1'b1;
        tick();

        // a=5: guess sequence 8,4,6,5 then eq
        a = 4'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t1_g8", 32'(bus.guess), 8);
        chk("t1_busy", 32'(bus.busy), 1);
        tick(); chk("t1_g4", 32'(bus.guess), 4);
        tick(); chk("t1_g6", 32'(bus.guess), 6);
        tick(); chk("t1_g5", 32'(bus.guess), 5);
        chk("t1_busy4", 32'(bus.busy), 1);
        chk("t1_nodone", 32'(bus.done), 0);
        tick();
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_result", 32'(bus.result), 5);
        chk("t1_busy_fall", 32'(bus.busy), 0);
        tick();
        chk("t1_done_pulse", 32'(bus.done), 0);
        chk("t1_guess_hold", 32'(bus.guess), 5);
        chk("t1_result_hold", 32'(bus.result), 5);

        // a=8: eq on first compare
        run(4'd8, n);
        chk("t2_cyc", 32'(n), 1);
        chk("t2_result", 32'(bus.result), 8);
        tick();
        chk("t2_guess", 32'(bus.guess), 8);

        // a=0: all lt, full length
        run(4'd0, n);
        chk("t3_a0_cyc", 32'(n), 4);
        chk("t3_a0_result", 32'(bus.result), 0);
        tick();
        chk("t3_a0_guess", 32'(bus.guess), 1);
        // a=15: 8,12,14,15 then eq at the last step
        run(4'd15, n);
        chk("t3_a15_cyc", 32'(n), 4);
        chk("t3_a15_result", 32'(bus.result), 15);
        tick();

        // start re-pulsed mid-search is ignored
        a = 4'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        dones = bus.done ? 1 : 0;
        repeat (8) begin
            tick();
            if (bus.done) dones++;
        end
        chk("t4_single_done", 32'(dones), 1);
        chk("t4_result", 32'(bus.result), 5);
        chk("t4_idle", 32'(bus.busy), 0);

        // reset in cycle 2 of a search
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t4_rst_guess", 32'(bus.guess), 0);
        chk("t4_rst_busy", 32'(bus.busy), 0);
        chk("t4_rst_result", 32'(bus.result), 0);
        dones = 0;
        repeat (3) begin
            tick();
            if (bus.done) dones++;
        end
        chk("t4_rst_nodone", 32'(dones), 0);
        rst_n = 1'b1;
        tick();

        // start held high: restarts on the edge right after done
        a = 4'd8;
        bus.start = 1'b1;
        tick();
        tick();
        chk("t4_hold_done", 32'(bus.done), 1);
        tick();
        chk("t4_hold_restart", 32'(bus.busy), 1);
        bus.start = 1'b0;
        tick();
        tick();

        // flag fault at step 2 (guess=4): gt=lt=1
        a = 4'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("t5_g4", 32'(bus.guess), 4);
        fz = 1'b1; fgt = 1'b1; flt = 1'b1; feq = 1'b0;
        tick();
        fz = 1'b0;
`ifdef SAR_ONEHOT_CHECK_EN
        chk("t5_err", 32'(bus.err), 1);
        chk("t5_done", 32'(bus.done), 1);
        chk("t5_result", 32'(bus.result), 4);
        tick();
        chk("t5_err_hold", 32'(bus.err), 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t5_err_clear", 32'(bus.err), 0);
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
        chk("t5_recover", 32'(bus.result), 5);
        tick();
`else
        // lt wins: bit 2 cleared, bit 1 set -> 2; then 3 kept to the end
        chk("t6_err", 32'(bus.err), 0);
        chk("t6_guess", 32'(bus.guess), 2);
        chk("t6_nodone", 32'(bus.done), 0);
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
        chk("t6_result", 32'(bus.result), 3);
        chk("t6_cyc", 32'(n), 2);
        tick();
`endif

        for (int v = 0; v < 16; v++) begin
            run(4'(v), n);
            chk($sformatf("ex_result_%0d", v), 32'(bus.result), 32'(v));
            chk($sformatf("ex_bound_%0d", v), 32'(n >= 1 && n <= 4), 1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
